bt656_rx: RTL and testbench
===========================

Name: bt656_rx

Overview:
- Receiver/decoder for the 8-bit ITU-R BT.656 byte stream produced by the team's BT.656 generator.
- Parses the FF-00-00-XY timing reference codes and tracks field, vertical blanking and active region.
- Packs active-line Cb/Y and Cr/Y byte pairs into 16-bit words.
- Emits one Avalon-ST-style packet per active line (valid/sop/eop, no backpressure), feeding the downstream AST video path.

Parameters:
- DATA_WIDTH, 8, input byte width (fixed BT.656; only 8 supported).
- MAX_WORDS, 720, maximum 16-bit words per active line; excess words are dropped.
- CHECK_PROT, 0, 1 = verify XY protection bits [3:0] and reject bad codes; 0 = ignore [3:0].

Ports:
- clock, in, 1, byte clock (27 MHz nominal); all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- data, in, 8, BT.656 byte stream, one byte per clock.
- out_data, out, 16, [15:8] = chroma byte (Cb/Cr), [7:0] = following Y byte.
- out_valid, out, 1, word valid (one-cycle strobe).
- out_sop, out, 1, first word of an active line; qualified by out_valid.
- out_eop, out, 1, last word of an active line; qualified by out_valid.
- out_field, out, 1, F bit of the line being emitted; qualified by out_valid.
- out_line, out, 11, active-line index within the current field, starting at 0; qualified by out_valid.
- locked, out, 1, high after a valid XY; low after reset or sync_error.
- sync_error, out, 1, one-cycle pulse: header sequence aborted.
- xy_error, out, 1, one-cycle pulse: protection mismatch (CHECK_PROT = 1 only).
- len_error, out, 1, one-cycle pulse at EAV: line word count ≠ MAX_WORDS.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0.
  - State SEARCH; held word invalid; counters 0.
  - Reset mid-line discards the held word; no eop is issued.
- FSM states: SEARCH, HDR1, HDR2, HDR3, BLANK, ACTIVE.
- Header detection:
  - data = FF in any state → HDR1 (FF never occurs inside valid video).
  - HDR1: 00 → HDR2, else → SEARCH.
  - HDR2: 00 → HDR3, else → SEARCH.
  - An abort out of HDR1/HDR2 pulses sync_error, clears locked and discards the held word.
- HDR3 decodes XY as F = bit6, V = bit5, H = bit4.
  - If bit7 = 0, treat as an abort (same as above).
  - If CHECK_PROT = 1 and [3:0] ≠ {V^H, F^H, F^V, F^V^H}: pulse xy_error, go to SEARCH, locked unchanged.
  - Otherwise set locked, latch F.
  - H = 1 (EAV) → BLANK.
  - H = 0 (SAV) with V = 0 → ACTIVE; word count 0, byte phase = chroma, next word tagged sop.
  - H = 0 (SAV) with V = 1 → BLANK.
- BLANK: all bytes ignored until FF.
- ACTIVE:
  - Even byte: captured as chroma.
  - Odd byte completes a word and increments the word count.
  - Words with count > MAX_WORDS are dropped.
- One-word holding register (this is what makes eop exact):
  - When a word completes and a held word is valid, the held word is emitted on the next edge: out_valid = 1 with its sop. The new word then becomes held.
  - On a valid EAV XY while the held word is valid, the held word is emitted at the edge after XY with out_eop = 1, and the held register is cleared.
  - A one-word line emits sop = eop = 1 in the same beat.
- Latency:
  - Word k (k < last) appears 2 byte-clocks after its Y byte.
  - The last word appears 1 clock after the XY byte of the EAV.
- Side-band values:
  - out_field is the F latched at SAV.
  - out_line increments on each emitted eop.
  - out_line resets to 0 on the first valid XY whose F differs from the previous F.
- len_error pulses together with the eop beat when the line's total word count ≠ MAX_WORDS.
- Sync loss inside ACTIVE: a header aborted after FF discards the held word, so the packet is truncated with no eop. Downstream treats a new sop as an implicit abort.
- Simultaneous events: an FF byte arriving on a chroma phase clears the byte phase; a partial word is never emitted.
- All error pulses are registered, one cycle wide, and asserted on the edge after the offending byte.

Test Plan:
- Full line: SAV (80), 1440 bytes alternating 99/00, EAV (90) → 720 beats.
  - Beat 0 has sop and out_data = 9900.
  - Beat 719 has eop and appears 1 clock after the EAV XY byte.
  - len_error = 0 and out_line = 0.
- Blank-line SAV (XY = A0/AB) followed by bytes → no out_valid.
- Field change: two lines with F = 0, then SAV with F = 1 (XY = C0) → out_line sequence 0, 1, 0; out_field = 1 on the third packet.
- Short line: SAV, 10 bytes, EAV → 5 beats, sop on beat 0, eop on beat 4, len_error pulses with the eop beat.
- Sync loss: FF 00 55 mid-line → sync_error pulse, locked = 0, no eop.
  - The next valid SAV/line produces a clean sop…eop packet and locked = 1.
- With CHECK_PROT = 1, XY = 80 passes and XY = 90 (no protection) → xy_error and no state change.
- Reset asserted mid-ACTIVE → all outputs 0 the next cycle; no stale eop after release.

Source files
------------

// File: rtl/bt656_rx.sv
// BT.656 receiver: decodes FF-00-00-XY timing references and packs active-line
// Cb/Y, Cr/Y byte pairs into 16-bit words, one valid/sop/eop packet per line.
module bt656_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WORDS  = 720,
  parameter int CHECK_PROT = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_field,
  output logic [10:0]           out_line,
  output logic                  locked,
  output logic                  sync_error,
  output logic                  xy_error,
  output logic                  len_error
);

  localparam int CW = $clog2(MAX_WORDS + 2);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
  localparam logic [CW-1:0] SAT_CNT = CW'(MAX_WORDS + 1);

  typedef enum logic [2:0] {SEARCH, HDR1, HDR2, HDR3, BLANK, ACTIVE} state_t;
  state_t state, state_next;

  logic                  is_ff, is_00;
  logic                  f_bit, v_bit, h_bit;
  logic [3:0]            prot;
  logic                  hdr_abort, xy_ok, xy_bad, chroma_en, word_done;

  logic                  phase;
  logic [DATA_WIDTH-1:0] chroma;
  logic [15:0]           held_data;
  logic                  held_valid, held_sop, sop_pending;
  logic                  in_line, f_reg, line_f;
  logic [CW-1:0]         word_cnt;
  logic [10:0]           line_cnt;

  assign is_ff = (data == '1);
  assign is_00 = (data == '0);
  assign f_bit = data[6];
  assign v_bit = data[5];
  assign h_bit = data[4];
  assign prot  = {v_bit ^ h_bit, f_bit ^ h_bit, f_bit ^ v_bit, f_bit ^ v_bit ^ h_bit};

  always_ff @(posedge clock) begin
    if (reset) state <= SEARCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    hdr_abort  = 1'b0;
    xy_ok      = 1'b0;
    xy_bad     = 1'b0;
    chroma_en  = 1'b0;
    word_done  = 1'b0;
    if (is_ff) begin
      state_next = HDR1;
    end else begin
      case (state)
        HDR1: begin
          if (is_00) state_next = HDR2;
          else begin
            state_next = SEARCH;
            hdr_abort  = 1'b1;
          end
        end
        HDR2: begin
          if (is_00) state_next = HDR3;
          else begin
            state_next = SEARCH;
            hdr_abort  = 1'b1;
          end
        end
        HDR3: begin
          if (!data[7]) begin
            state_next = SEARCH;
            hdr_abort  = 1'b1;
          end else if (CHECK_PROT != 0 && data[3:0] != prot) begin
            state_next = SEARCH;
            xy_bad     = 1'b1;
          end else begin
            xy_ok      = 1'b1;
            state_next = (h_bit || v_bit) ? BLANK : ACTIVE;
          end
        end
        ACTIVE: begin
          chroma_en = !phase;
          word_done = phase;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_field   <= 1'b0;
      out_line    <= '0;
      locked      <= 1'b0;
      sync_error  <= 1'b0;
      xy_error    <= 1'b0;
      len_error   <= 1'b0;
      phase       <= 1'b0;
      chroma      <= '0;
      held_data   <= '0;
      held_valid  <= 1'b0;
      held_sop    <= 1'b0;
      sop_pending <= 1'b0;
      in_line     <= 1'b0;
      f_reg       <= 1'b0;
      line_f      <= 1'b0;
      word_cnt    <= '0;
      line_cnt    <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      sync_error <= 1'b0;
      xy_error   <= 1'b0;
      len_error  <= 1'b0;

      if (is_ff) phase <= 1'b0;

      if (hdr_abort) begin
        sync_error <= 1'b1;
        locked     <= 1'b0;
        held_valid <= 1'b0;
        in_line    <= 1'b0;
      end

      if (xy_bad) xy_error <= 1'b1;

      if (xy_ok) begin
        locked <= 1'b1;
        f_reg  <= f_bit;
        if (h_bit) begin
          // EAV: the held word is the last of the line and closes the packet
          if (held_valid) begin
            out_valid  <= 1'b1;
            out_data   <= held_data;
            out_sop    <= held_sop;
            out_eop    <= 1'b1;
            out_field  <= line_f;
            out_line   <= line_cnt;
            held_valid <= 1'b0;
          end
          if (in_line) len_error <= (word_cnt != MAX_CNT);
          in_line <= 1'b0;
        end else begin
          held_valid <= 1'b0;
          in_line    <= !v_bit;
          if (!v_bit) begin
            word_cnt    <= '0;
            phase       <= 1'b0;
            sop_pending <= 1'b1;
            line_f      <= f_bit;
          end
        end
        if (f_bit != f_reg)             line_cnt <= '0;
        else if (h_bit && held_valid)   line_cnt <= line_cnt + 11'd1;
      end

      if (chroma_en) begin
        chroma <= data;
        phase  <= 1'b1;
      end

      if (word_done) begin
        phase <= 1'b0;
        if (word_cnt != SAT_CNT) word_cnt <= word_cnt + 1'b1;
        // Words beyond MAX_WORDS leave the held word in place for the EAV eop
        if (word_cnt < MAX_CNT) begin
          if (held_valid) begin
            out_valid <= 1'b1;
            out_data  <= held_data;
            out_sop   <= held_sop;
            out_field <= line_f;
            out_line  <= line_cnt;
          end
          held_data   <= {chroma, data};
          held_sop    <= sop_pending;
          sop_pending <= 1'b0;
          held_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bt656_rx.sv
// Directed bench for bt656_rx: default instance (MAX_WORDS 720, no protection
// check) and a small instance (MAX_WORDS 4, protection check) on one byte stream.
module tb_bt656_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data  = 8'h00;

  logic [15:0] d0, d1;
  logic        v0, s0, e0, f0, lk0, se0, xe0, le0;
  logic        v1, s1, e1, f1, lk1, se1, xe1, le1;
  logic [10:0] l0, l1;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  int unsigned nb0, nsop0, neop0, nlen0, nsync0, nb1, neop1;
  logic        first_sop0;
  logic [15:0] first_data0;

  always #5 clock = ~clock;

  bt656_rx dut0 (
    .clock(clock), .reset(reset), .data(data),
    .out_data(d0), .out_valid(v0), .out_sop(s0), .out_eop(e0),
    .out_field(f0), .out_line(l0), .locked(lk0),
    .sync_error(se0), .xy_error(xe0), .len_error(le0)
  );

  bt656_rx #(.MAX_WORDS(4), .CHECK_PROT(1)) dut1 (
    .clock(clock), .reset(reset), .data(data),
    .out_data(d1), .out_valid(v1), .out_sop(s1), .out_eop(e1),
    .out_field(f1), .out_line(l1), .locked(lk1),
    .sync_error(se1), .xy_error(xe1), .len_error(le1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_acc();
    nb0 = 0; nsop0 = 0; neop0 = 0; nlen0 = 0; nsync0 = 0; nb1 = 0; neop1 = 0;
    first_sop0 = 1'b0; first_data0 = '0;
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    @(posedge clock);
    #1;
    if (v0) begin
      if (nb0 == 0) begin
        first_sop0  = s0;
        first_data0 = d0;
      end
      nb0++;
      if (s0) nsop0++;
      if (e0) neop0++;
    end
    if (le0) nlen0++;
    if (se0) nsync0++;
    if (v1) nb1++;
    if (v1 && e1) neop1++;
  endtask

  task automatic hdr(input logic [7:0] xy);
    send(8'hFF); send(8'h00); send(8'h00); send(xy);
  endtask

  task automatic payload(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) send(base + 8'(i));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    send(8'h00); send(8'h00);
    reset = 1'b0;
    clear_acc();
  endtask

  initial begin
    clear_acc();
    do_reset();
    check("reset_outs", {d0, v0, s0, e0, f0, l0, lk0, se0, xe0, le0}, '0);

    // full 720-word line
    hdr(8'h80);
    check("full_locked", lk0, 1'b1);
    for (int i = 0; i < 1440; i++) begin
      send((i % 2 == 0) ? 8'h99 : 8'h00);
      if (i == 2) check("full_latency_pre", v0, 1'b0);
      if (i == 3) check("full_beat0", {v0, s0, d0}, {2'b11, 16'h9900});
    end
    check("full_pre_eav", nb0, 719);
    send(8'hFF); send(8'h00); send(8'h00);
    check("full_hold_eop", v0, 1'b0);
    send(8'h90);
    check("full_eop", {v0, s0, e0, le0, l0}, {4'b1010, 11'd0});
    check("full_beats", nb0, 720);
    check("full_sop_eop_cnt", {nsop0[7:0], neop0[7:0]}, 16'h0101);

    // blanking lines produce nothing
    clear_acc();
    hdr(8'hA0); payload(8, 8'h10); hdr(8'hB6);
    hdr(8'hAB); payload(8, 8'h10); hdr(8'hB6);
    check("blank_beats", nb0, 0);
    check("blank_locked", lk0, 1'b1);

    // field change resets the line index
    do_reset();
    hdr(8'h80); payload(4, 8'h20); hdr(8'h9D);
    check("fld_line0", {e0, f0, l0}, {2'b10, 11'd0});
    hdr(8'h80); payload(4, 8'h20); hdr(8'h9D);
    check("fld_line1", {e0, f0, l0}, {2'b10, 11'd1});
    hdr(8'hC7); payload(4, 8'h20); hdr(8'hDA);
    check("fld_line2", {e0, f0, l0}, {2'b11, 11'd0});

    // short line: 5 words
    do_reset();
    hdr(8'h80); payload(10, 8'h10);
    check("short_pre_eav", nb0, 4);
    hdr(8'h9D);
    check("short_eop", {v0, e0, le0, d0}, {3'b111, 16'h1819});
    check("short_beats", nb0, 5);
    check("short_first", {first_sop0, first_data0}, {1'b1, 16'h1011});
    send(8'h00);
    check("short_len_pulse", le0, 1'b0);

    // sync loss mid-line
    do_reset();
    hdr(8'h80); payload(6, 8'h30);
    check("sync_pre_beats", nb0, 2);
    send(8'hFF); send(8'h00); send(8'h55);
    check("sync_err", {se0, lk0}, 2'b10);
    send(8'h00);
    check("sync_err_pulse", se0, 1'b0);
    payload(4, 8'h30);
    check("sync_no_eop", {nb0[7:0], neop0[7:0]}, 16'h0200);
    clear_acc();
    hdr(8'h80);
    check("sync_relock", lk0, 1'b1);
    payload(4, 8'h40);
    hdr(8'h9D);
    check("sync_clean_eop", {v0, e0, d0}, {2'b11, 16'h4243});
    check("sync_clean_pkt", {nb0[7:0], nsop0[7:0], first_sop0}, {16'h0201, 1'b1});

    // reset mid-active
    do_reset();
    hdr(8'h80); payload(6, 8'h50);
    check("rst_mid_beat", v0, 1'b1);
    reset = 1'b1;
    send(8'h99);
    check("rst_mid_outs", {d0, v0, s0, e0, f0, l0, lk0, se0, xe0, le0}, '0);
    reset = 1'b0;
    clear_acc();
    payload(3, 8'h60); hdr(8'h9D); payload(2, 8'h60);
    check("rst_no_stale", {nb0[7:0], neop0[7:0], nlen0[7:0]}, 24'h000000);

    // protection check and word-limit instance
    do_reset();
    hdr(8'h80);
    check("prot_sav_ok", {lk1, xe1}, 2'b10);
    payload(8, 8'h00);
    check("prot_pre_beats", nb1, 3);
    hdr(8'h90);
    check("prot_xy_err", {xe1, v1, lk1}, 3'b101);
    send(8'hFF);
    check("prot_xy_pulse", xe1, 1'b0);
    send(8'h00); send(8'h00); send(8'h9D);
    check("prot_eop", {v1, e1, le1, d1}, {3'b110, 16'h0607});
    check("prot_beats", nb1, 4);
    clear_acc();
    hdr(8'h80); payload(12, 8'h00); hdr(8'h9D);
    check("drop_eop", {v1, e1, le1, d1}, {3'b111, 16'h0607});
    check("drop_beats", {nb1[7:0], neop1[7:0]}, 16'h0401);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
